// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared OOO pipeline types: ROB tags and scoreboard entries
package rv32i_types_pkg;

  localparam int SB_NUM_REGS  = 32;
  localparam int SB_ROB_DEPTH = 16;
  localparam int SB_TAG_W     = $clog2(SB_ROB_DEPTH);
  localparam int NUM_WB_PORTS = 4;

  typedef logic [SB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic     busy;
    logic     ready;
    rob_tag_t tag;
  } sb_entry_t;

endpackage

// File: rtl/ooo_sb_entry.sv
// rtl/ooo_sb_entry.sv - one architectural register's busy/ready/tag state
// Update priority: flush > dispatch > commit clear > writeback ready-set.
module ooo_sb_entry
  import rv32i_types_pkg::*;
#(
  parameter int NUM_WB = NUM_WB_PORTS
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         disp_sel_i,
  input  rob_tag_t                     disp_tag_i,
  input  logic                         commit_sel_i,
  input  rob_tag_t                     commit_tag_i,
  input  logic [NUM_WB-1:0]            wb_valid_i,
  input  logic [NUM_WB*SB_TAG_W-1:0]   wb_tag_i,
  output sb_entry_t                    entry_o
);

  sb_entry_t entry_q, entry_d;
  logic      wb_hit;
  logic      commit_clr;

  always_comb begin
    wb_hit = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid_i[i] && (wb_tag_i[i*SB_TAG_W +: SB_TAG_W] == entry_q.tag)) begin
        wb_hit = 1'b1;
      end
    end
    wb_hit = wb_hit & entry_q.busy;
  end

  // A tag mismatch on commit means a younger producer now owns the register.
  assign commit_clr = commit_sel_i & entry_q.busy & (entry_q.tag == commit_tag_i);

  always_comb begin
    entry_d = entry_q;
    if (flush_i) begin
      entry_d = '0;
    end else if (disp_sel_i) begin
      entry_d.busy  = 1'b1;
      entry_d.ready = 1'b0;
      entry_d.tag   = disp_tag_i;
    end else if (commit_clr) begin
      entry_d.busy  = 1'b0;
      entry_d.ready = 1'b0;
    end else if (wb_hit) begin
      entry_d.ready = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/ooo_reg_scoreboard.sv
// rtl/ooo_reg_scoreboard.sv - per-register busy/tag tracker feeding hazard unit and dispatch
// All outputs are combinational lookups of registered state; same-cycle updates are not bypassed.
module ooo_reg_scoreboard
  import rv32i_types_pkg::*;
#(
  parameter int NUM_REGS  = SB_NUM_REGS,
  parameter int ROB_DEPTH = SB_ROB_DEPTH,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int NUM_WB    = NUM_WB_PORTS
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [4:0]              rd,
  input  logic                    rs1_used,
  input  logic                    rs2_used,
  input  logic                    wen,
  input  logic                    dispatch_en,
  input  logic [TAG_W-1:0]        dispatch_tag,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic                    commit_valid,
  input  logic [4:0]              commit_rd,
  input  logic [TAG_W-1:0]        commit_tag,
  input  logic                    flush,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    rd_busy,
  output logic [TAG_W-1:0]        rs1_tag,
  output logic [TAG_W-1:0]        rs2_tag,
  output logic                    rs1_in_rob,
  output logic                    rs2_in_rob,
  output logic                    data_hazard
);

  sb_entry_t entries [NUM_REGS];
  sb_entry_t rs1_e, rs2_e;

  // x0 is hardwired and never tracked.
  assign entries[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    ooo_sb_entry #(
      .NUM_WB(NUM_WB)
    ) u_entry (
      .clk_i        (CLK),
      .rst_ni       (nRST),
      .flush_i      (flush),
      .disp_sel_i   (dispatch_en & wen & (rd == 5'(r))),
      .disp_tag_i   (dispatch_tag),
      .commit_sel_i (commit_valid & (commit_rd == 5'(r))),
      .commit_tag_i (commit_tag),
      .wb_valid_i   (wb_valid),
      .wb_tag_i     (wb_tag),
      .entry_o      (entries[r])
    );
  end

  assign rs1_e = entries[rs1];
  assign rs2_e = entries[rs2];

  assign rs1_busy    = rs1_e.busy & ~rs1_e.ready;
  assign rs2_busy    = rs2_e.busy & ~rs2_e.ready;
  assign rs1_in_rob  = rs1_e.busy & rs1_e.ready;
  assign rs2_in_rob  = rs2_e.busy & rs2_e.ready;
  assign rs1_tag     = rs1_e.tag;
  assign rs2_tag     = rs2_e.tag;
  assign rd_busy     = entries[rd].busy;
  assign data_hazard = (rs1_used & rs1_busy) | (rs2_used & rs2_busy);

endmodule
